// File: rtl/saf_mon_pkg.sv
// Shared types and sizing helpers for the adaptive-filter monitors.
// Holds the monitor state encoding and the MSE accumulator width.
package saf_mon_pkg;

   typedef enum logic [1:0] {
      ST_WARM = 2'd0,
      ST_ACQ  = 2'd1,
      ST_CONV = 2'd2,
      ST_DIV  = 2'd3
   } mon_state_t;

   // A window of 2^win_log2 full-width squares never overflows this many bits.
   function automatic int acc_w(input int width, input int win_log2);
      return 2 * width + win_log2;
   endfunction

endpackage

// File: rtl/sq_accum.sv
// Square-and-accumulate datapath: input register, square register, window accumulator
// with rounded/saturated mean output. Optional peak tracking under MSE_PEAK_EN.
module sq_accum
   import saf_mon_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int QP       = 12,
   parameter int WIN_LOG2 = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] err_in,
   input  logic             in_valid,
   input  logic             in_last,
   output logic [WIDTH-1:0] mse_out,
   output logic             mse_valid
`ifdef MSE_PEAK_EN
   ,
   output logic [WIDTH-1:0] peak_out
`endif
);

   localparam int ACC_W = acc_w(WIDTH, WIN_LOG2);
   localparam int SH    = WIN_LOG2 + QP;
   localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (SH - 1);

   logic [WIDTH-1:0]          err_q;
   logic                      v1, last1;
   logic [2*WIDTH-1:0]        sq_q;
   logic                      v2, last2;
   logic [ACC_W-1:0]          acc;
   logic signed [2*WIDTH-1:0] prod;
   logic [ACC_W:0]            sum, rounded, shifted;
   logic [WIDTH-1:0]          mse_sat;

   assign prod    = $signed(err_q) * $signed(err_q);
   assign sum     = {1'b0, acc} + (ACC_W + 1)'(sq_q);
   assign rounded = sum + RND;
   assign shifted = rounded >> SH;
   assign mse_sat = (|shifted[ACC_W:WIDTH]) ? '1 : shifted[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q     <= '0;
         v1        <= 1'b0;
         last1     <= 1'b0;
         sq_q      <= '0;
         v2        <= 1'b0;
         last2     <= 1'b0;
         acc       <= '0;
         mse_out   <= '0;
         mse_valid <= 1'b0;
      end else begin
         v1    <= in_valid;
         last1 <= in_valid & in_last;
         if (in_valid) err_q <= err_in;
         v2    <= v1;
         last2 <= v1 & last1;
         if (v1) sq_q <= prod;
         mse_valid <= 1'b0;
         // The closing sample folds into the mean directly; acc restarts for the next window.
         if (v2) begin
            if (last2) begin
               acc       <= '0;
               mse_out   <= mse_sat;
               mse_valid <= 1'b1;
            end else begin
               acc <= sum[ACC_W-1:0];
            end
         end
      end
   end

`ifdef MSE_PEAK_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   logic [WIDTH-1:0] abs_q, peak_acc, abs_d, peak_next;

   always_comb begin
      abs_d = err_q;
      if (err_q == MOST_NEG) abs_d = {1'b0, {(WIDTH-1){1'b1}}};
      else if (err_q[WIDTH-1]) abs_d = -err_q;
   end

   assign peak_next = (abs_q > peak_acc) ? abs_q : peak_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         abs_q    <= '0;
         peak_acc <= '0;
         peak_out <= '0;
      end else begin
         if (v1) abs_q <= abs_d;
         if (v2) begin
            if (last2) begin
               peak_acc <= '0;
               peak_out <= peak_next;
            end else begin
               peak_acc <= peak_next;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/mse_monitor.sv
// Windowed MSE convergence monitor: warm-up discard, window framing and the
// WARM/ACQ/CONV/DIV state machine around sq_accum. MSE_PEAK_EN adds peak_out.
module mse_monitor
   import saf_mon_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int QP       = 12,
   parameter int WIN_LOG2 = 7,
   parameter int WARMUP   = 64,
   parameter int HOLD     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] err_in,
   input  logic             err_valid,
   input  logic [WIDTH-1:0] threshold,
   output logic [WIDTH-1:0] mse_out,
   output logic             mse_valid,
   output logic [1:0]       state,
   output logic             converged
`ifdef MSE_PEAK_EN
   ,
   output logic [WIDTH-1:0] peak_out
`endif
);

   localparam int WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int HB_W = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
   localparam mon_state_t RST_ST = (WARMUP == 0) ? ST_ACQ : ST_WARM;
   localparam logic [HB_W:0] HOLD_V = (HB_W + 1)'(HOLD);

   mon_state_t          st_q, st_d;
   logic [HB_W-1:0]     below_q, below_d;
   logic [HB_W:0]       below_inc;
   logic [WIN_LOG2-1:0] win_cnt;
   logic [WU_W-1:0]     warm_cnt;
   logic                accept_win, win_last;
   logic                mse_is_sat, below_thr, above_2thr;

   assign accept_win = err_valid && (st_q != ST_WARM);
   assign win_last   = accept_win && (win_cnt == '1);

   sq_accum #(
      .WIDTH    (WIDTH),
      .QP       (QP),
      .WIN_LOG2 (WIN_LOG2)
   ) u_sq_accum (
      .clk       (clk),
      .reset     (reset),
      .err_in    (err_in),
      .in_valid  (accept_win),
      .in_last   (win_last),
      .mse_out   (mse_out),
      .mse_valid (mse_valid)
`ifdef MSE_PEAK_EN
      ,
      .peak_out  (peak_out)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q     <= RST_ST;
         below_q  <= '0;
         win_cnt  <= '0;
         warm_cnt <= '0;
      end else begin
         st_q    <= st_d;
         below_q <= below_d;
         if (accept_win) win_cnt <= win_cnt + WIN_LOG2'(1);
         if (st_q == ST_WARM && err_valid) warm_cnt <= warm_cnt + WU_W'(1);
      end
   end

   assign mse_is_sat = (mse_out == '1);
   assign below_thr  = (mse_out < threshold);
   // 2*threshold needs one extra bit so large thresholds do not wrap.
   assign above_2thr = ({1'b0, mse_out} >= {threshold, 1'b0});
   assign below_inc  = {1'b0, below_q} + (HB_W + 1)'(1);

   always_comb begin
      st_d    = st_q;
      below_d = below_q;
      case (st_q)
         ST_WARM: begin
            if (err_valid && warm_cnt == WU_W'(WARMUP - 1)) st_d = ST_ACQ;
         end
         ST_ACQ: begin
            if (mse_valid) begin
               if (mse_is_sat) begin
                  st_d = ST_DIV;
               end else if (below_thr) begin
                  if (below_inc >= HOLD_V) begin
                     st_d    = ST_CONV;
                     below_d = '0;
                  end else begin
                     below_d = below_inc[HB_W-1:0];
                  end
               end else begin
                  below_d = '0;
               end
            end
         end
         ST_CONV: begin
            if (mse_valid) begin
               if (mse_is_sat) begin
                  st_d = ST_DIV;
               end else if (above_2thr) begin
                  st_d    = ST_ACQ;
                  below_d = '0;
               end
            end
         end
         default: st_d = ST_DIV;
      endcase
   end

   assign state     = st_q;
   assign converged = (st_q == ST_CONV);

endmodule

// File: tb/tb_mse_monitor.sv
// Bench for mse_monitor (WIDTH=16, QP=12, WIN_LOG2=3, WARMUP=4, HOLD=2): directed window
// table, multi-cycle corner sequences and random traffic against a window-mean model.
module tb_mse_monitor;

   localparam int WIDTH = 16;
   localparam int QP = 12;
   localparam int WIN_LOG2 = 3;
   localparam int WARMUP = 4;
   localparam int HOLD = 2;
   localparam int WIN = 1 << WIN_LOG2;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] err_in;
   logic             err_valid;
   logic [WIDTH-1:0] threshold;
   logic [WIDTH-1:0] mse_out;
   logic             mse_valid;
   logic [1:0]       state;
   logic             converged;
`ifdef MSE_PEAK_EN
   logic [WIDTH-1:0] peak_out;
`endif

   int checks = 0;
   int errors = 0;

   mse_monitor #(
      .WIDTH(WIDTH), .QP(QP), .WIN_LOG2(WIN_LOG2), .WARMUP(WARMUP), .HOLD(HOLD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .err_in    (err_in),
      .err_valid (err_valid),
      .threshold (threshold),
      .mse_out   (mse_out),
      .mse_valid (mse_valid),
      .state     (state),
      .converged (converged)
`ifdef MSE_PEAK_EN
      ,
      .peak_out  (peak_out)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state: window sum of squares, pending mean results
   int             m_state;
   int             m_warm;
   int             m_below;
   int             m_win_n;
   longint         m_win_sum;
   int             cyc;
   int             pulse_cnt;
   logic [WIDTH-1:0] exp_q[$];
   int             exp_cyc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_state   = (WARMUP == 0) ? 1 : 0;
      m_warm    = 0;
      m_below   = 0;
      m_win_n   = 0;
      m_win_sum = 0;
      exp_q.delete();
      exp_cyc_q.delete();
   endtask

   // Called once per clock, 1 time unit after the rising edge.
   task automatic model_step();
      int e;
      longint m;
      logic [WIDTH-1:0] mv;
      cyc++;
      if (mse_valid) pulse_cnt++;
      if (err_valid) begin
         if (m_state == 0) begin
            m_warm++;
            if (m_warm == WARMUP) m_state = 1;
         end else begin
            e = $signed(err_in);
            m_win_sum += longint'(e) * longint'(e);
            m_win_n++;
            if (m_win_n == WIN) begin
               m = (m_win_sum + (longint'(1) << (WIN_LOG2 + QP - 1))) >> (WIN_LOG2 + QP);
               if (m > 65535) m = 65535;
               exp_q.push_back(WIDTH'(m));
               exp_cyc_q.push_back(cyc + 2);
               m_win_n   = 0;
               m_win_sum = 0;
            end
         end
      end
      chk("state", 32'(state), 32'(m_state));
      chk("converged", 32'(converged), 32'(m_state == 2));
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
         mv = exp_q.pop_front();
         void'(exp_cyc_q.pop_front());
         chk("mse_valid_pulse", 32'(mse_valid), 32'd1);
         chk("mse_out", 32'(mse_out), 32'(mv));
         if (mv == 16'hFFFF && (m_state == 1 || m_state == 2)) begin
            m_state = 3;
         end else if (m_state == 1) begin
            if (mv < threshold) begin
               m_below++;
               if (m_below >= HOLD) begin
                  m_state = 2;
                  m_below = 0;
               end
            end else begin
               m_below = 0;
            end
         end else if (m_state == 2) begin
            if (int'(mv) >= 2 * int'(threshold)) begin
               m_state = 1;
               m_below = 0;
            end
         end
      end else begin
         chk("mse_valid_idle", 32'(mse_valid), 32'd0);
      end
   endtask

   // driver tasks
   task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] e);
      @(negedge clk);
      err_valid = v;
      err_in    = e;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      err_valid = 1'b0;
      err_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_mse_out", 32'(mse_out), 32'd0);
      chk("rst_mse_valid", 32'(mse_valid), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_converged", 32'(converged), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [WIDTH-1:0] err_a;
      logic [WIDTH-1:0] err_b;
      logic [WIDTH-1:0] thr;
      logic [WIDTH-1:0] mse;
      logic [1:0]       st;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int lat;
      int pulses0;
      int amp;
      logic [WIDTH-1:0] thr_opts[3];

      reset     = 1'b1;
      err_valid = 1'b0;
      err_in    = '0;
      threshold = '0;
      cyc       = 0;
      pulse_cnt = 0;
      model_reset();

      tbl[0] = '{16'h1000, 16'hF000, 16'h0100, 16'h1000, 2'd1};
      tbl[1] = '{16'h1000, 16'hF000, 16'h0100, 16'h1000, 2'd1};
      tbl[2] = '{16'h0040, 16'h0040, 16'h0100, 16'h0001, 2'd1};
      tbl[3] = '{16'h0040, 16'h0040, 16'h0100, 16'h0001, 2'd2};
      tbl[4] = '{16'h0040, 16'hFFC0, 16'h0100, 16'h0001, 2'd2};
      tbl[5] = '{16'h0800, 16'h0800, 16'h0100, 16'h0400, 2'd1};
      tbl[6] = '{16'h7FFF, 16'h7FFF, 16'h0100, 16'hFFFF, 2'd3};
      tbl[7] = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 2'd3};

      // 12 continuous samples: 4 warm-up, one window, result two edges later
      do_reset();
      threshold = 16'h0100;
      for (int i = 0; i < 12; i++) drive_cycle(1'b1, 16'h0800);
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         drive_cycle(1'b0, 16'h0000);
         if (mse_valid) lat = k;
      end
      chk("first_latency", 32'(lat), 32'd2);
      chk("first_mse", 32'(mse_out), 32'h0400);

      // directed window table
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         threshold = tbl[t].thr;
         for (int i = 0; i < WIN; i++) drive_cycle(1'b1, (i % 2 == 0) ? tbl[t].err_a : tbl[t].err_b);
         repeat (3) drive_cycle(1'b0, 16'h0000);
         chk($sformatf("tbl%0d_mse", t), 32'(mse_out), 32'(tbl[t].mse));
         chk($sformatf("tbl%0d_state", t), 32'(state), 32'(tbl[t].st));
      end

      // valid toggling, then reset 5 samples into a window
      do_reset();
      threshold = 16'h0100;
      pulses0 = pulse_cnt;
      for (int i = 0; i < 2 * (WARMUP + 5); i++) drive_cycle(i % 2 == 0, 16'h0100);
      do_reset();
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, 16'h0000);
      chk("no_pulse_after_reset", 32'(pulse_cnt - pulses0), 32'd0);
      for (int i = 0; i < 2 * (WARMUP + WIN - 1); i++) drive_cycle(i % 2 == 0, 16'h0200);
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'h0000);
      chk("pulse_before_full_window", 32'(pulse_cnt - pulses0), 32'd0);
      drive_cycle(1'b1, 16'h0200);
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'h0000);
      chk("pulse_after_full_window", 32'(pulse_cnt - pulses0), 32'd1);

      // random traffic against the model
      thr_opts[0] = 16'h0100;
      thr_opts[1] = 16'h0400;
      thr_opts[2] = 16'h1000;
      for (int seg = 0; seg < 5; seg++) begin
         do_reset();
         threshold = thr_opts[$urandom_range(0, 2)];
         amp = 64;
         for (int i = 0; i < 300; i++) begin
            if (i % 40 == 0) begin
               case ($urandom_range(0, 4))
                  0: amp = 64;
                  1: amp = 256;
                  2: amp = 2048;
                  3: amp = 8192;
                  default: amp = 32767;
               endcase
            end
            drive_cycle($urandom_range(0, 3) != 0,
                        WIDTH'(int'($urandom_range(0, 2 * amp)) - amp));
         end
         for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'h0000);
         chk("rand_drained", 32'(exp_q.size()), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mse_monitor.md
MSE_MONITOR -- requirements
Module: mse_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the error sample width (signed, two's complement).
REQ-002 SHALL have parameter QP, default 12, giving the number of fractional bits of the error and MSE words.
REQ-003 SHALL have parameter WIN_LOG2, default 7; window length is 2^WIN_LOG2 accepted samples.
REQ-004 SHALL have parameter WARMUP, default 64; this many accepted samples are discarded after reset (covers the filter pipeline fill).
REQ-005 SHALL have parameter HOLD, default 4; this many consecutive windows below threshold are needed to declare convergence.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 err_in  input  WIDTH  signed error sample, QP fractional bits (the adaptive filter's registered error output).
REQ-009 err_valid  input  1  err_in is accepted on every rising edge where this is high.
REQ-010 threshold  input  WIDTH  unsigned MSE convergence threshold, QP fractional bits; sampled at each window end.
REQ-011 mse_out  output  WIDTH  unsigned windowed mean-square error, QP fractional bits.
REQ-012 mse_valid  output  1  single-cycle pulse marking a new mse_out.
REQ-013 state  output  2  monitor state: WARM=0, ACQ=1, CONV=2, DIV=3.
REQ-014 converged  output  1  high while state==CONV.

Function
REQ-015 Squaring: SHALL compute err_in*err_in as a full 2*WIDTH product and register it one cycle after acceptance, tagged with a last-of-window flag.
REQ-016 Accumulator: SHALL be 2*WIDTH+WIN_LOG2 bits unsigned; it cannot overflow within one window.
REQ-017 Window end: if the last sample of a window is accepted at edge t, then at edge t+2 mse_out SHALL load (acc+sq + 2^(WIN_LOG2+QP-1)) >> (WIN_LOG2+QP), saturated to 2^WIDTH-1; mse_valid SHALL be high for the cycle after edge t+2; acc SHALL clear to 0 on the same edge.
REQ-018 A sample accepted at edge t+1 SHALL be included in the next window; back-to-back windows SHALL lose no samples.
REQ-019 err_valid low SHALL freeze the window count and add nothing to acc; the square stage still drains its pending product.
REQ-020 WARM: discard accepted samples, counting them; after the WARMUP-th sample go to ACQ, with the window count at 0.
REQ-021 ACQ: at each mse_valid, if mse_out < threshold, increment the below-count, else clear it; when it reaches HOLD, go to CONV.
REQ-022 CONV: at mse_valid, if mse_out >= 2*threshold (computed at WIDTH+1 bits), go to ACQ and clear the below-count; otherwise stay.
REQ-023 DIV: entered from ACQ or CONV at any mse_valid where the saturated mse_out == 2^WIDTH-1; DIV is sticky until reset, and mse_out/mse_valid keep updating.
REQ-024 Saturation has priority over the convergence rules in the same window.
REQ-025 WARMUP=0 SHALL start in ACQ directly after reset.

Reset
REQ-026 On reset: mse_out=0, mse_valid=0, state=WARM (or ACQ when WARMUP=0), converged=0, and acc, square register, window, warmup and below counters all 0.
REQ-027 Reset mid-window SHALL discard the partial window and any in-flight square; no mse_valid pulse follows it.

Configuration
REQ-028 MSE_PEAK_EN defined: add output peak_out (WIDTH, unsigned) = max |err_in| over the window, updated with mse_out on the same edge; |−2^(WIDTH-1)| saturates to 2^(WIDTH-1)-1; reset value 0.
REQ-029 MSE_PEAK_EN undefined: there is no peak_out port and no peak logic.

Structure
REQ-030 State encodings (WARM/ACQ/CONV/DIV) and the accumulator-width expression SHALL live in the shared package saf_mon_pkg.
REQ-031 Square-and-accumulate with rounding/saturation SHALL be one sub-module, sq_accum; the FSM and counters stay in mse_monitor.

Verification (bench: WIDTH=16, QP=12, WIN_LOG2=3, WARMUP=4, HOLD=2)
REQ-032 12 samples of err_in=0x0800 continuous -> first 4 discarded; mse_out=0x0400 with mse_valid exactly 2 cycles after the 12th sample.
REQ-033 err_in alternating 0x1000/0xF000 with threshold=0x0100 -> mse_out=0x1000 every window; state stays ACQ.
REQ-034 err_in=0x0040 (mse 0x0001), threshold=0x0100 -> CONV after 2nd window; then err_in=0x0800 -> mse 0x0400 >= 0x0200, back to ACQ.
REQ-035 err_in=0x7FFF for one window -> mse_out=0xFFFF, state=DIV; later err_in=0 -> mse_out=0, state stays DIV.
REQ-036 err_valid toggled 1/0 each cycle, plus reset after 5 window samples -> windows complete after 8 accepted samples only; after reset no mse_valid until WARMUP+8 new samples.
